// File: rtl/adder_init_pkg.sv
// Shared types and constants for the adder initiator and its operand FIFO.
package adder_init_pkg;

    localparam int unsigned DefaultW       = 16;
    localparam int unsigned DefaultDepth   = 4;
    localparam int unsigned DefaultTimeout = 8;
    localparam int unsigned DefaultGap     = 2;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StGap
    } init_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO; an extra pointer bit distinguishes full from empty.
module op_fifo
    import adder_init_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DefaultW,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: reset empties the FIFO via the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/adder_initiator.sv
// Drives a single-cycle registered adder core from a buffered operand stream,
// returns sums downstream and flags missing or unexpected core responses.
module adder_initiator
    import adder_init_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned DEPTH   = DefaultDepth,
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned GAP     = DefaultGap
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic         valid,
    input  logic [W-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_err,
    output logic         err_timeout,
    output logic         err_spurious,
    output logic         busy
);

    localparam int unsigned TW = cnt_width(TIMEOUT);
    localparam int unsigned GW = cnt_width(GAP);

    logic [2*W-1:0] fifo_rdata;
    logic           fifo_full, fifo_empty, fifo_pop;

    init_state_e    state_q, state_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic           err_q, err_d;
    logic           timeout_q, timeout_d;
    logic           spurious_q, spurious_d;

    assign in_ready = !fifo_full;

    op_fifo #(
        .WIDTH(2 * W),
        .DEPTH(DEPTH)
    ) u_op_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (in_valid),
        .wdata({in_a, in_b}),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        err_d      = err_q;
        timeout_d  = timeout_q;
        fifo_pop   = 1'b0;
        // A core strobe is only meaningful while a request is outstanding.
        spurious_d = spurious_q | (valid && (state_q != StWait));

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    {a_d, b_d} = fifo_rdata;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (valid) begin
                    sum_d   = y;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    sum_d     = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (GAP == 0) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end
                end
            end
            StGap: begin
                if (32'(gap_cnt_q) + 32'd1 >= GAP) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign start        = (state_q == StIssue);
    assign out_valid    = (state_q == StHold);
    assign a            = a_q;
    assign b            = b_q;
    assign out_sum      = sum_q;
    assign out_err      = err_q;
    assign err_timeout  = timeout_q;
    assign err_spurious = spurious_q;
    assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: doc/adder_initiator.md
# adder_initiator

Initiator for the single-cycle registered adder core (`start` pulse in, `valid` plus `y` one cycle later). The block accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO. It issues one `start` pulse per pair with operands held stable, and returns each sum on a downstream valid/ready stream. It sits between the request producer and the adder core and owns latency supervision: a missing or spurious core `valid` is flagged.

## Interface
- `W`, 16, operand and sum width
- `DEPTH`, 4, operand FIFO entries (power of two, ≥2)
- `TIMEOUT`, 8, cycles in WAIT without core `valid` before a timeout result (≥2)
- `GAP`, 2, idle cycles forced between the end of one transaction and the next `start` (≥0)

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — upstream operand pair valid
- `in_ready` out 1 — FIFO not full
- `in_a`, `in_b` in W — operands
- `start` out 1 — one-cycle request pulse to the core
- `a`, `b` out W — operands to the core, stable from ISSUE through end of WAIT
- `valid` in 1 — core result strobe
- `y` in W — core sum
- `out_valid` out 1 — result available
- `out_ready` in 1 — downstream accepts
- `out_sum` out W — captured sum, or 0 on timeout
- `out_err` out 1 — result is a timeout, qualified by `out_valid`
- `err_timeout` out 1 — sticky, set on any timeout
- `err_spurious` out 1 — sticky, set on core `valid` outside WAIT
- `busy` out 1 — FSM not in IDLE or FIFO not empty

## Operation
- FIFO push on `in_valid && in_ready`. Pop on the IDLE→ISSUE transition.
- FSM states: IDLE, ISSUE, WAIT, HOLD, GAP.
  - **IDLE:** if the FIFO is non-empty, pop into `a`/`b` and go to ISSUE.
  - **ISSUE:** `start`=1 for exactly this cycle; clear the wait counter; go to WAIT.
  - **WAIT:** counter increments each cycle.
    - If `valid`=1: capture `y` into `out_sum`, `out_err`=0, go to HOLD.
    - Else if the counter reaches TIMEOUT−1: `out_sum`=0, `out_err`=1, set `err_timeout`, go to HOLD.
  - **HOLD:** `out_valid`=1. When `out_ready`=1, go to GAP (or IDLE if GAP=0).
  - **GAP:** count GAP cycles, then go to IDLE.
- `out_sum`/`out_err` are stable while `out_valid`=1 and `out_ready`=0.
- `valid` in any state other than WAIT sets `err_spurious` and is otherwise ignored. This includes a late `valid` after a timeout.
- Arithmetic is performed by the core only. `out_sum` is `y` verbatim, W bits, with no carry out.
- Sticky flags clear only on reset.
- Simultaneous push and pop when the FIFO is full is not possible, because `in_ready`=0 blocks the push. When the FIFO is empty, push and pop in the same cycle cannot happen: a pop requires an entry registered on a prior cycle.
- FIFO pointers wrap modulo DEPTH; full/empty are derived from an extra pointer bit.

## Timing
- Reset values: `start`=0, `a`=`b`=0, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_err`=0, `err_timeout`=`err_spurious`=0, `busy`=0, FSM=IDLE, FIFO empty.
- Reset asserted mid-transaction aborts it immediately. The FIFO contents are discarded and outputs return to their reset values asynchronously.
- Pair accepted at edge t into an empty FIFO with the FSM in IDLE:
  - `start`=1 in cycle t+2 (IDLE pops at t+1 edge, ISSUE registered).
  - A conforming core raises `valid` in cycle t+3.
  - `out_valid`=1 from cycle t+4.
- All outputs are registered; there is no combinational path from `valid`/`y`/`out_ready` to any output.
- Back-to-back throughput with `out_ready` tied high: one result per 4+GAP cycles.

## Structure
- Package `adder_init_pkg`: FSM state enum `init_state_e`, default parameter constants, and the counter-width function `$clog2(TIMEOUT)`.
- Sub-module `op_fifo` (sync FIFO, 2W wide, DEPTH entries, full/empty outputs). Instantiate it once.
- FSM, counters, and result registers live in the top module.

## Test plan
- **Single transaction:** push a=0x0003, b=0x0005; model core responds in 1 cycle → `start` pulse exactly once, `out_valid` with `out_sum`=0x0008, `out_err`=0.
- **FIFO fill:** push 5 pairs with `out_ready`=0 → `in_ready` drops after 4 pushes plus the one in flight. Releasing `out_ready` returns all 5 sums in order, with ≥GAP idle cycles between `start` pulses.
- **Wrap-around sum:** a=0xFFFF, b=0x0002 → `out_sum`=0x0001.
- **Timeout:** core never asserts `valid` → after 8 WAIT cycles `out_valid`=1, `out_err`=1, `out_sum`=0, `err_timeout`=1 and it stays set.
- **Spurious valid:** pulse core `valid` while IDLE → `err_spurious`=1, no `out_valid`, next transaction completes normally.
- **Reset mid-WAIT:** drop `rst_n` during WAIT with 2 pairs queued → all outputs at reset values; after release `busy`=0 and no stale result appears.
